// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch datapath: field limits, run-state
// encoding and a width helper used to sanity-check the sub-second field.
package stopwatch_pkg;

  localparam int SECS_MAX = 59;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } run_state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int width_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/stopwatch_mod_counter.sv
// Mod-(MAX+1) counter with enable, synchronous clear and a saturate input.
// carry is combinational: high on an enabled cycle while the count sits at
// MAX, so a whole chain of these settles within one clock.
module stopwatch_mod_counter #(
  parameter int W   = 7,
  parameter int MAX = 99
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         sat,
  output logic [W-1:0] cnt,
  output logic         carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: clear wins, saturation holds, otherwise wrap at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !sat) begin
      cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt   = cnt_q;
  assign carry = en && (cnt_q == MAX_V);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch datapath: start/stop run FSM, hundredths/seconds/minutes chain
// qualified by tick_en, sticky saturating overflow and a registered display.
// Optional feature macro: STOPWATCH_LAP_EN -- when defined, hold freezes
// only the display (split/lap); when undefined, hold pauses counting.
// start_stop is registered once before edge detection, so a level first
// sampled at edge N takes effect on the run state at edge N+1.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int MAX_MINS      = 99,
  parameter int DECS_W        = 7
) (
  input  logic              CLK_100Hz,
  input  logic              reset_n,
  input  logic              tick_en,
  input  logic              start_stop,
  input  logic              hold,
  input  logic              clear,
  output logic [6:0]        stopwatch_unit_mins,
  output logic [5:0]        stopwatch_unit_secs,
  output logic [DECS_W-1:0] stopwatch_unit_decs,
  output logic              running,
  output logic              stopwatch_overflow
);

  if (DECS_W < width_for(TICKS_PER_SEC - 1)) begin : g_bad_decs_w
    $error("DECS_W too narrow for TICKS_PER_SEC-1");
  end

  run_state_e        state_d, state_q;
  logic              ovf_d, ovf_q;
  logic              start_sync_q, start_q;
  logic              rise, count_en, at_max, sat_hit, freeze;
  logic              decs_carry, secs_carry, mins_carry;
  logic [DECS_W-1:0] decs_live, disp_decs_d, disp_decs_q;
  logic [5:0]        secs_live, disp_secs_d, disp_secs_q;
  logic [6:0]        mins_live, disp_mins_d, disp_mins_q;

  assign rise = start_sync_q && !start_q;

`ifdef STOPWATCH_LAP_EN
  assign count_en = (state_q == RUNNING) && tick_en && !ovf_q;
  assign freeze   = hold;
`else
  assign count_en = (state_q == RUNNING) && tick_en && !ovf_q && !hold;
  assign freeze   = 1'b0;
`endif

  assign at_max  = (decs_live == DECS_W'(TICKS_PER_SEC - 1)) &&
                   (secs_live == 6'(SECS_MAX)) &&
                   (mins_live == 7'(MAX_MINS));
  assign sat_hit = count_en && at_max;

  stopwatch_mod_counter #(.W(DECS_W), .MAX(TICKS_PER_SEC - 1)) u_decs (
    .clk(CLK_100Hz), .rst_n(reset_n), .en(count_en), .clr(clear),
    .sat(at_max), .cnt(decs_live), .carry(decs_carry)
  );

  stopwatch_mod_counter #(.W(6), .MAX(SECS_MAX)) u_secs (
    .clk(CLK_100Hz), .rst_n(reset_n), .en(decs_carry), .clr(clear),
    .sat(at_max), .cnt(secs_live), .carry(secs_carry)
  );

  stopwatch_mod_counter #(.W(7), .MAX(MAX_MINS)) u_mins (
    .clk(CLK_100Hz), .rst_n(reset_n), .en(secs_carry), .clr(clear),
    .sat(at_max), .cnt(mins_live), .carry(mins_carry)
  );

  // Run FSM and sticky overflow: clear first, then saturation, then toggles.
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = STOPPED;
      ovf_d   = 1'b0;
    end else if (sat_hit) begin
      state_d = STOPPED;
      ovf_d   = 1'b1;
    end else begin
      case (state_q)
        STOPPED: if (rise && !ovf_q) state_d = RUNNING;
        RUNNING: if (rise)           state_d = STOPPED;
        default:                     state_d = STOPPED;
      endcase
    end
  end

  // Display registers follow the live counters one edge later unless frozen.
  always_comb begin
    disp_mins_d = disp_mins_q;
    disp_secs_d = disp_secs_q;
    disp_decs_d = disp_decs_q;
    if (clear) begin
      disp_mins_d = '0;
      disp_secs_d = '0;
      disp_decs_d = '0;
    end else if (!freeze) begin
      disp_mins_d = mins_live;
      disp_secs_d = secs_live;
      disp_decs_d = decs_live;
    end
  end

  // State, edge-detect and display registers.
  always_ff @(posedge CLK_100Hz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= STOPPED;
      ovf_q        <= 1'b0;
      start_sync_q <= 1'b0;
      start_q      <= 1'b0;
      disp_mins_q  <= '0;
      disp_secs_q  <= '0;
      disp_decs_q  <= '0;
    end else begin
      state_q      <= state_d;
      ovf_q        <= ovf_d;
      start_sync_q <= start_stop;
      start_q      <= start_sync_q;
      disp_mins_q  <= disp_mins_d;
      disp_secs_q  <= disp_secs_d;
      disp_decs_q  <= disp_decs_d;
    end
  end

  assign stopwatch_unit_mins = disp_mins_q;
  assign stopwatch_unit_secs = disp_secs_q;
  assign stopwatch_unit_decs = disp_decs_q;
  assign running             = (state_q == RUNNING);
  assign stopwatch_overflow  = ovf_q;

  // The minute carry has no consumer: minutes saturate instead of wrapping.
  logic unused_ok;
  assign unused_ok = mins_carry;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core (TICKS_PER_SEC=100, MAX_MINS=2).
// Vector table covers start/stop, tick qualification, display latency and
// hold; hand sequences cover carry chain, overflow, clear and async reset.
module tb_stopwatch_core;

  localparam int TPS  = 100;
  localparam int MAXM = 2;
  localparam int DW   = 7;
`ifdef STOPWATCH_LAP_EN
  localparam int LAP_ADD = 50;
`else
  localparam int LAP_ADD = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_en = 1'b0;
  logic          start_stop = 1'b0;
  logic          hold = 1'b0;
  logic          clear = 1'b0;
  logic [6:0]    mins;
  logic [5:0]    secs;
  logic [DW-1:0] decs;
  logic          running;
  logic          ovf;

  int errors = 0;
  int checks = 0;

  stopwatch_core #(.TICKS_PER_SEC(TPS), .MAX_MINS(MAXM), .DECS_W(DW)) dut (
    .CLK_100Hz(clk), .reset_n(rst_n), .tick_en(tick_en),
    .start_stop(start_stop), .hold(hold), .clear(clear),
    .stopwatch_unit_mins(mins), .stopwatch_unit_secs(secs),
    .stopwatch_unit_decs(decs), .running(running), .stopwatch_overflow(ovf)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  typedef struct {
    logic  ss;
    logic  te;
    logic  hd;
    logic  clr;
    int    cycles;
    int    m;
    int    s;
    int    d;
    logic  r;
    logic  o;
    string name;
  } vec_t;

  vec_t vec_q[$];

  task automatic add(input logic ss, input logic te, input logic hd,
                     input logic clr, input int cycles, input int m,
                     input int s, input int d, input logic r, input logic o,
                     input string name);
    vec_t v;
    v.ss = ss; v.te = te; v.hd = hd; v.clr = clr; v.cycles = cycles;
    v.m = m; v.s = s; v.d = d; v.r = r; v.o = o; v.name = name;
    vec_q.push_back(v);
  endtask

  // Advance n active edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int m, input int s,
                       input int d, input logic r, input logic o);
    checks++;
    if (mins !== 7'(m) || secs !== 6'(s) || decs !== DW'(d) ||
        running !== r || ovf !== o) begin
      errors++;
      $display("FAIL %s: got %0d:%0d:%0d run=%0b ovf=%0b, expected %0d:%0d:%0d run=%0b ovf=%0b",
               name, mins, secs, decs, running, ovf, m, s, d, r, o);
    end
  endtask

  initial begin
    // ss te hd clr cycles  m  s  d            run ovf
    add(0, 0, 0, 0,   2,   0, 0, 0,           0, 0, "reset_state");
    add(1, 1, 0, 0,   1,   0, 0, 0,           0, 0, "start_sampled");
    add(1, 1, 0, 0,   1,   0, 0, 0,           1, 0, "running_next_edge");
    add(1, 1, 0, 0, 100,   0, 0, 99,          1, 0, "display_lags_live");
    add(1, 0, 0, 0,   1,   0, 1, 0,           1, 0, "one_second");
    add(1, 0, 0, 0,   5,   0, 1, 0,           1, 0, "tick_en_low_idle");
    add(1, 1, 1, 0,  50,   0, 1, 0,           1, 0, "hold_display");
    add(1, 0, 0, 0,   1,   0, 1, LAP_ADD,     1, 0, "hold_release");
    add(1, 1, 0, 0,  10,   0, 1, 9 + LAP_ADD, 1, 0, "resume_count");
    add(0, 1, 0, 0,   1,   0, 1, 10 + LAP_ADD, 1, 0, "ss_fall_no_effect");
    add(0, 0, 0, 0,   1,   0, 1, 11 + LAP_ADD, 1, 0, "ss_low_settle");
    add(1, 1, 0, 0,   1,   0, 1, 11 + LAP_ADD, 1, 0, "rise_sampled");
    add(1, 1, 0, 0,   1,   0, 1, 12 + LAP_ADD, 0, 0, "rise_stops");
    add(1, 1, 0, 0,   5,   0, 1, 13 + LAP_ADD, 0, 0, "stopped_no_count");
    add(0, 1, 0, 1,   1,   0, 0, 0,           0, 0, "clear_when_stopped");

    #12 rst_n = 1'b1;

    foreach (vec_q[i]) begin
      start_stop = vec_q[i].ss;
      tick_en    = vec_q[i].te;
      hold       = vec_q[i].hd;
      clear      = vec_q[i].clr;
      step(vec_q[i].cycles);
      check(vec_q[i].name, vec_q[i].m, vec_q[i].s, vec_q[i].d,
            vec_q[i].r, vec_q[i].o);
    end
    clear = 1'b0;

    // Carry chain: 0:59:99 -> 1:00:00 in one edge.
    start_stop = 1'b1; tick_en = 1'b0;
    step(2);
    tick_en = 1'b1;
    step(5999);
    tick_en = 1'b0;
    step(1);
    check("at_0_59_99", 0, 59, 99, 1, 0);
    tick_en = 1'b1;
    step(1);
    check("carry_edge_display_lag", 0, 59, 99, 1, 0);
    tick_en = 1'b0;
    step(1);
    check("carry_to_1_00_00", 1, 0, 0, 1, 0);

    // Overflow at MAX_MINS:59:99.
    tick_en = 1'b1;
    step(11999);
    tick_en = 1'b0;
    step(1);
    check("at_max_no_ovf", 2, 59, 99, 1, 0);
    tick_en = 1'b1;
    step(1);
    check("saturating_tick", 2, 59, 99, 0, 1);
    step(1);
    check("saturated_hold", 2, 59, 99, 0, 1);
    start_stop = 1'b0;
    step(2);
    start_stop = 1'b1;
    step(3);
    check("rise_ignored_in_ovf", 2, 59, 99, 0, 1);

    // Clear together with a rise and a tick.
    start_stop = 1'b0;
    step(2);
    start_stop = 1'b1;
    step(1);
    clear = 1'b1; tick_en = 1'b1;
    step(1);
    check("clear_priority", 0, 0, 0, 0, 0);
    clear = 1'b0;
    step(2);
    check("clear_swallowed_rise", 0, 0, 0, 0, 0);

    // Asynchronous reset mid-count.
    start_stop = 1'b0; tick_en = 1'b0;
    step(2);
    start_stop = 1'b1;
    step(2);
    tick_en = 1'b1;
    step(30);
    check("count_before_reset", 0, 0, 29, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 0, 0, 0, 0, 0);
    start_stop = 1'b0;
    #3 rst_n = 1'b1;
    step(3);
    check("after_reset_idle", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
